simon_seq_engine: RTL and testbench

- Parametrised successor to the Simon datapath. Stores a player-entered LED sequence of configurable depth and button count.
- Replays the stored sequence step by step, checks repeat attempts, and loops the sequence in the done phase.
- Sits between the Simon control FSM and the board switches/LEDs.
- Adds: generic LED count, full/saturation flags, a mode-change pointer reset, looping done replay, and a multi-button "level" rule.

---
 rtl/simon_pkg.sv | 15 +
 rtl/simon_seq_engine_if.sv | 37 +++
 rtl/simon_seq_mem.sv | 35 +++
 rtl/simon_seq_engine.sv | 126 ++++++++++++
 tb/tb_simon_seq_engine.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/simon_pkg.sv
// Shared definitions for the Simon sequence engine: mode encoding and
// default sizing constants.
package simon_pkg;

    typedef enum logic [1:0] {
        MODE_INPUT    = 2'd0,
        MODE_PLAYBACK = 2'd1,
        MODE_REPEAT   = 2'd2,
        MODE_DONE     = 2'd3
    } mode_t;

    localparam int DEF_NUM_LEDS = 4;
    localparam int DEF_DEPTH    = 64;

endpackage

// File: rtl/simon_seq_engine_if.sv
// Bundle between the Simon control FSM / board I/O (master) and the
// sequence engine (slave).
interface simon_seq_engine_if
    import simon_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int DEPTH    = DEF_DEPTH
) ();
    localparam int ADDR_W = $clog2(DEPTH);

    logic                level;
    logic [NUM_LEDS-1:0] pattern;
    mode_t               mode;
    logic                step;
    logic                clrcount;
    logic                w_en;
    logic                is_legal;
    logic                seq_full;
    logic                play_done;
    logic                repeat_done;
    logic                input_eq_pattern;
    logic [ADDR_W:0]     seq_len;
    logic [NUM_LEDS-1:0] pattern_leds;

    modport master (
        output level, pattern, mode, step, clrcount, w_en,
        input  is_legal, seq_full, play_done, repeat_done,
               input_eq_pattern, seq_len, pattern_leds
    );

    modport slave (
        input  level, pattern, mode, step, clrcount, w_en,
        output is_legal, seq_full, play_done, repeat_done,
               input_eq_pattern, seq_len, pattern_leds
    );

endinterface

// File: rtl/simon_seq_mem.sv
// DEPTH x NUM_LEDS sequence store: one write port, one synchronous
// read-first read port. The array itself is never reset so it maps to
// block RAM; only the read register is cleared.
module simon_seq_mem #(
    parameter int NUM_LEDS = 4,
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [NUM_LEDS-1:0] wdata,
    input  logic [ADDR_W-1:0]   raddr,
    output logic [NUM_LEDS-1:0] rdata
);
    logic [NUM_LEDS-1:0] mem [DEPTH];

    // Write port: store the appended pattern.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered every cycle, returns old data on a same-address write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/simon_seq_engine.sv
// Simon sequence engine: records a player-entered LED sequence, replays
// it, compares repeat attempts and loops it in the done phase.
module simon_seq_engine
    import simon_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    simon_seq_engine_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W + 1)'(1);

    mode_t               mode_q;
    logic                level_q;
    logic [ADDR_W:0]     count;
    logic [ADDR_W:0]     ptr;
    logic [ADDR_W:0]     ptr_inc;
    logic [ADDR_W:0]     ptr_next;
    logic [NUM_LEDS-1:0] rd_data;
    logic [NUM_LEDS-1:0] leds_q;
    logic                is_legal;
    logic                seq_full;
    logic                play_done;
    logic                repeat_done;
    logic                mode_changed;
    logic                wr_en;

    // Legality: nonzero, and one-hot unless the latched level allows chords.
    always_comb begin
        is_legal = 1'b0;
        if (bus.pattern != '0) begin
            is_legal = level_q || ((bus.pattern & (bus.pattern - NUM_LEDS'(1))) == '0);
        end
    end

    assign seq_full     = (count == DEPTH_C);
    assign play_done    = (bus.mode == MODE_PLAYBACK) && (ptr == count);
    assign repeat_done  = (bus.mode == MODE_REPEAT) && (ptr == count);
    assign mode_changed = (bus.mode != mode_q);
    assign ptr_inc      = ptr + ONE;
    // clrcount wins over a same-cycle append.
    assign wr_en        = !bus.clrcount && (bus.mode == MODE_INPUT) && bus.w_en
                          && is_legal && !seq_full;

    // Pointer update: cleared on clrcount or any mode change, else mode-specific stepping.
    always_comb begin
        ptr_next = ptr;
        if (bus.clrcount || mode_changed) begin
            ptr_next = '0;
        end else begin
            case (bus.mode)
                MODE_PLAYBACK, MODE_REPEAT: begin
                    if (bus.step && (ptr < count)) begin
                        ptr_next = ptr_inc;
                    end
                end
                MODE_DONE: begin
                    // Wrap after the last entry; an empty sequence keeps ptr at 0.
                    if (bus.step) begin
                        ptr_next = (ptr_inc >= count) ? '0 : ptr_inc;
                    end
                end
                default: ptr_next = '0;
            endcase
        end
    end

    // Control state: mode history, level latch, sequence length and read pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q  <= MODE_INPUT;
            level_q <= 1'b0;
            count   <= '0;
            ptr     <= '0;
        end else begin
            mode_q <= bus.mode;
            ptr    <= ptr_next;
            if (bus.clrcount) begin
                count   <= '0;
                level_q <= bus.level;
            end else if (wr_en) begin
                count <= count + ONE;
            end
        end
    end

    // LED drive: live switches while entering/repeating, stored data while replaying.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            leds_q <= '0;
        end else if ((bus.mode == MODE_INPUT) || (bus.mode == MODE_REPEAT)) begin
            leds_q <= bus.pattern;
        end else if (play_done || (count == '0)) begin
            leds_q <= '0;
        end else begin
            leds_q <= rd_data;
        end
    end

    simon_seq_mem #(
        .NUM_LEDS (NUM_LEDS),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_en),
        .waddr (count[ADDR_W-1:0]),
        .wdata (bus.pattern),
        .raddr (ptr[ADDR_W-1:0]),
        .rdata (rd_data)
    );

    assign bus.is_legal         = is_legal;
    assign bus.seq_full         = seq_full;
    assign bus.play_done        = play_done;
    assign bus.repeat_done      = repeat_done;
    assign bus.input_eq_pattern = (bus.pattern == rd_data);
    assign bus.seq_len          = count;
    assign bus.pattern_leds     = leds_q;

endmodule

// File: tb/tb_simon_seq_engine.sv
// Directed bench for simon_seq_engine: a default 64-deep instance for most
// scenarios and a 4-deep instance for the full/saturation case.
module tb_simon_seq_engine;
    import simon_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    simon_seq_engine_if #(.NUM_LEDS(4), .DEPTH(64)) bus ();
    simon_seq_engine_if #(.NUM_LEDS(4), .DEPTH(4))  bus4 ();

    simon_seq_engine #(.NUM_LEDS(4), .DEPTH(64)) dut (.clk(clk), .rst(rst), .bus(bus));
    simon_seq_engine #(.NUM_LEDS(4), .DEPTH(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr(input logic lvl);
        bus.level    = lvl;
        bus.clrcount = 1'b1;
        tick();
        bus.clrcount = 1'b0;
        $display("clrcount level=%0d", lvl);
    endtask

    task automatic wr(input logic [3:0] p);
        bus.pattern = p;
        bus.w_en    = 1'b1;
        tick();
        bus.w_en    = 1'b0;
        $display("write pattern=%b seq_len=%0d", p, bus.seq_len);
    endtask

    task automatic pulse_step();
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        $display("step ptr=%0d", dut.ptr);
    endtask

    task automatic set_mode(input mode_t m);
        bus.mode = m;
        tick();
        $display("mode=%0d", m);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.seq_len !== 7'd0) begin failures++; $display("FAIL reset_seq_len got=%0d exp=0", bus.seq_len); end
        checks++; if (bus.pattern_leds !== 4'b0000) begin failures++; $display("FAIL reset_leds got=%b exp=0000", bus.pattern_leds); end
        checks++; if (bus.seq_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", bus.seq_full); end
        checks++; if (bus.is_legal !== 1'b0) begin failures++; $display("FAIL reset_legal got=%b exp=0", bus.is_legal); end
        checks++; if (bus.play_done !== 1'b0) begin failures++; $display("FAIL reset_play_done got=%b exp=0", bus.play_done); end
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic test_level();
        set_mode(MODE_INPUT);
        clr(1'b0);
        bus.pattern = 4'b0110;
        #1;
        checks++; if (bus.is_legal !== 1'b0) begin failures++; $display("FAIL level0_legal got=%b exp=0", bus.is_legal); end
        wr(4'b0110);
        checks++; if (bus.seq_len !== 7'd0) begin failures++; $display("FAIL level0_len got=%0d exp=0", bus.seq_len); end
        clr(1'b1);
        #1;
        checks++; if (bus.is_legal !== 1'b1) begin failures++; $display("FAIL level1_legal got=%b exp=1", bus.is_legal); end
        wr(4'b0110);
        checks++; if (bus.seq_len !== 7'd1) begin failures++; $display("FAIL level1_len got=%0d exp=1", bus.seq_len); end
        bus.pattern = 4'b0000;
        #1;
        checks++; if (bus.is_legal !== 1'b0) begin failures++; $display("FAIL zero_legal got=%b exp=0", bus.is_legal); end
    endtask

    task automatic test_record_replay();
        logic [3:0] exp_leds [2];
        exp_leds[0] = 4'b0100;
        exp_leds[1] = 4'b1000;
        set_mode(MODE_INPUT);
        clr(1'b0);
        wr(4'b0001);
        wr(4'b0100);
        wr(4'b1000);
        checks++; if (bus.seq_len !== 7'd3) begin failures++; $display("FAIL rec_len got=%0d exp=3", bus.seq_len); end
        set_mode(MODE_PLAYBACK);
        checks++; if (bus.pattern_leds !== 4'b0001) begin failures++; $display("FAIL play_led0 got=%b exp=0001", bus.pattern_leds); end
        checks++; if (bus.play_done !== 1'b0) begin failures++; $display("FAIL play_done_early got=%b exp=0", bus.play_done); end
        for (int i = 0; i < 2; i++) begin
            pulse_step();
            tick();
            tick();
            checks++; if (bus.pattern_leds !== exp_leds[i]) begin failures++; $display("FAIL play_led%0d got=%b exp=%b", i + 1, bus.pattern_leds, exp_leds[i]); end
        end
        pulse_step();
        checks++; if (bus.play_done !== 1'b1) begin failures++; $display("FAIL play_done got=%b exp=1", bus.play_done); end
        tick();
        checks++; if (bus.pattern_leds !== 4'b0000) begin failures++; $display("FAIL play_done_leds got=%b exp=0000", bus.pattern_leds); end
        pulse_step();
        checks++; if (dut.ptr !== 7'd3) begin failures++; $display("FAIL play_saturate got=%0d exp=3", dut.ptr); end
        // A mode change swallows a coincident step and clears the pointer.
        bus.mode = MODE_REPEAT;
        bus.step = 1'b1;
        tick();
        bus.step = 1'b0;
        checks++; if (dut.ptr !== 7'd0) begin failures++; $display("FAIL mode_change_ptr got=%0d exp=0", dut.ptr); end
    endtask

    task automatic test_repeat();
        set_mode(MODE_INPUT);
        clr(1'b0);
        wr(4'b0001);
        wr(4'b0100);
        set_mode(MODE_REPEAT);
        tick();
        bus.pattern = 4'b0001;
        #1;
        checks++; if (bus.input_eq_pattern !== 1'b1) begin failures++; $display("FAIL rep_eq0 got=%b exp=1", bus.input_eq_pattern); end
        checks++; if (bus.repeat_done !== 1'b0) begin failures++; $display("FAIL rep_done_early got=%b exp=0", bus.repeat_done); end
        pulse_step();
        tick();
        bus.pattern = 4'b0010;
        #1;
        checks++; if (bus.input_eq_pattern !== 1'b0) begin failures++; $display("FAIL rep_eq1 got=%b exp=0", bus.input_eq_pattern); end
        bus.pattern = 4'b0100;
        #1;
        checks++; if (bus.input_eq_pattern !== 1'b1) begin failures++; $display("FAIL rep_eq1_match got=%b exp=1", bus.input_eq_pattern); end
        bus.pattern = 4'b0010;
        pulse_step();
        checks++; if (bus.repeat_done !== 1'b1) begin failures++; $display("FAIL rep_done got=%b exp=1", bus.repeat_done); end
        checks++; if (bus.pattern_leds !== 4'b0010) begin failures++; $display("FAIL rep_leds got=%b exp=0010", bus.pattern_leds); end
    endtask

    task automatic test_done_wrap();
        int exp_ptr [7];
        exp_ptr = '{1, 2, 0, 1, 2, 0, 1};
        set_mode(MODE_INPUT);
        clr(1'b0);
        wr(4'b0001);
        wr(4'b0010);
        wr(4'b0100);
        set_mode(MODE_DONE);
        for (int i = 0; i < 7; i++) begin
            pulse_step();
            checks++; if (dut.ptr !== 7'(exp_ptr[i])) begin failures++; $display("FAIL done_ptr%0d got=%0d exp=%0d", i, dut.ptr, exp_ptr[i]); end
        end
        set_mode(MODE_INPUT);
        clr(1'b0);
        set_mode(MODE_DONE);
        pulse_step();
        checks++; if (dut.ptr !== 7'd0) begin failures++; $display("FAIL done_empty_ptr got=%0d exp=0", dut.ptr); end
    endtask

    task automatic test_priority();
        set_mode(MODE_INPUT);
        clr(1'b1);
        wr(4'b0001);
        checks++; if (bus.seq_len !== 7'd1) begin failures++; $display("FAIL prio_pre_len got=%0d exp=1", bus.seq_len); end
        bus.pattern  = 4'b0011;
        bus.clrcount = 1'b1;
        bus.w_en     = 1'b1;
        tick();
        bus.clrcount = 1'b0;
        bus.w_en     = 1'b0;
        checks++; if (bus.seq_len !== 7'd0) begin failures++; $display("FAIL prio_len got=%0d exp=0", bus.seq_len); end
        tick();
        checks++; if (dut.u_mem.mem[1] !== 4'b0010) begin failures++; $display("FAIL prio_mem1 got=%b exp=0010", dut.u_mem.mem[1]); end
    endtask

    task automatic test_reset_mid();
        set_mode(MODE_INPUT);
        clr(1'b1);
        wr(4'b0001);
        wr(4'b0010);
        wr(4'b0100);
        wr(4'b1000);
        wr(4'b0001);
        checks++; if (bus.seq_len !== 7'd5) begin failures++; $display("FAIL mid_pre_len got=%0d exp=5", bus.seq_len); end
        bus.pattern = 4'b0110;
        tick();
        checks++; if (bus.is_legal !== 1'b1) begin failures++; $display("FAIL mid_pre_legal got=%b exp=1", bus.is_legal); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.seq_len !== 7'd0) begin failures++; $display("FAIL mid_len got=%0d exp=0", bus.seq_len); end
        checks++; if (bus.pattern_leds !== 4'b0000) begin failures++; $display("FAIL mid_leds got=%b exp=0000", bus.pattern_leds); end
        checks++; if (bus.is_legal !== 1'b0) begin failures++; $display("FAIL mid_legal got=%b exp=0", bus.is_legal); end
        bus.pattern = 4'b0100;
        #1;
        checks++; if (bus.is_legal !== 1'b1) begin failures++; $display("FAIL mid_legal_onehot got=%b exp=1", bus.is_legal); end
        rst = 1'b0;
        bus.mode = MODE_PLAYBACK;
        tick();
        checks++; if (bus.play_done !== 1'b1) begin failures++; $display("FAIL mid_play_done got=%b exp=1", bus.play_done); end
        $display("reset mid-sequence seq_len=%0d", bus.seq_len);
    endtask

    task automatic test_full();
        logic [3:0] pats [5];
        pats = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0010};
        bus4.mode     = MODE_INPUT;
        bus4.level    = 1'b0;
        bus4.clrcount = 1'b1;
        tick();
        bus4.clrcount = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus4.pattern = pats[k];
            bus4.w_en    = 1'b1;
            tick();
            bus4.w_en    = 1'b0;
            $display("write4 pattern=%b seq_len=%0d", pats[k], bus4.seq_len);
            checks++; if (bus4.seq_full !== (k >= 3)) begin failures++; $display("FAIL full_flag%0d got=%b exp=%b", k, bus4.seq_full, (k >= 3)); end
            checks++; if (bus4.seq_len !== 3'((k < 4) ? k + 1 : 4)) begin failures++; $display("FAIL full_len%0d got=%0d exp=%0d", k, bus4.seq_len, (k < 4) ? k + 1 : 4); end
        end
        bus4.mode = MODE_PLAYBACK;
        tick();
        tick();
        checks++; if (bus4.pattern_leds !== 4'b0001) begin failures++; $display("FAIL full_mem0 got=%b exp=0001", bus4.pattern_leds); end
        checks++; if (bus4.play_done !== 1'b0) begin failures++; $display("FAIL full_play_done got=%b exp=0", bus4.play_done); end
    endtask

    initial begin
        rst           = 1'b1;
        bus.level     = 1'b0;
        bus.pattern   = '0;
        bus.mode      = MODE_INPUT;
        bus.step      = 1'b0;
        bus.clrcount  = 1'b0;
        bus.w_en      = 1'b0;
        bus4.level    = 1'b0;
        bus4.pattern  = '0;
        bus4.mode     = MODE_INPUT;
        bus4.step     = 1'b0;
        bus4.clrcount = 1'b0;
        bus4.w_en     = 1'b0;
        test_reset();
        test_level();
        test_record_replay();
        test_repeat();
        test_done_wrap();
        test_priority();
        test_full();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
